// File: rtl/seg7_scan_decoder.sv
// Snoops a scanned 4-digit seven-segment bus, decodes each digit and publishes the signed
// frame value once it has been identical over STABLE_FRAMES consecutive frames.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE        = 2,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned TIMEOUT       = 2097151
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg7_in,
    input  logic [3:0]  seg7_sel_in,
    output logic [14:0] value,
    output logic        value_strobe,
    output logic        frame_err,
    output logic        stale
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned RW = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SettleMax = SW'(SETTLE);
    localparam logic [RW-1:0] RunMax    = RW'(STABLE_FRAMES);
    localparam logic [TW-1:0] TmoMax    = TW'(TIMEOUT);
    localparam logic [3:0]    DigMinus  = 4'd10;

    typedef enum logic [1:0] {StIdle, StCollect, StAssemble} state_e;

    // Returns {valid, code}; blank decodes as a valid 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   return {1'b1, 4'd0};
            7'h06:   return {1'b1, 4'd1};
            7'h5B:   return {1'b1, 4'd2};
            7'h4F:   return {1'b1, 4'd3};
            7'h66:   return {1'b1, 4'd4};
            7'h6D:   return {1'b1, 4'd5};
            7'h7D:   return {1'b1, 4'd6};
            7'h07:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h6F:   return {1'b1, 4'd9};
            7'h40:   return {1'b1, DigMinus};
            7'h00:   return {1'b1, 4'd0};
            default: return 5'b0_0000;
        endcase
    endfunction

    logic             unused_dp;
    logic [3:0]       sel_s1_q, sel_s2_q;
    logic [6:0]       seg_s1_q, seg_s2_q;
    logic [10:0]      smp_q;
    logic [SW-1:0]    cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic [14:0]      frame_v_q, frame_v_d;
    logic             frame_done_q, frame_done_d;
    logic [14:0]      prev_v_q, prev_v_d;
    logic [RW-1:0]    run_q, run_d;
    logic [14:0]      value_q, value_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic        accept, acc_ok, acc_err, idle_sel, onehot, minus_bad;
    logic [4:0]  dec;
    logic [1:0]  pos;
    logic [3:0]  base_mask, mask_acc;
    logic [14:0] mag, asm_v;

    assign unused_dp = seg7_in[7];

    // Settle: count includes the current sample, so a fresh value counts as 1.
    always_comb begin
        cnt_d = cnt_q;
        if ({sel_s2_q, seg_s2_q} != smp_q) begin
            cnt_d = SW'(1);
        end else if (cnt_q != SettleMax) begin
            cnt_d = cnt_q + SW'(1);
        end
        accept = (cnt_d == SettleMax) &&
                 ((cnt_q != SettleMax) || ({sel_s2_q, seg_s2_q} != smp_q));
    end

    always_comb begin
        pos = 2'd0;
        unique case (sel_s2_q)
            4'b0001: pos = 2'd0;
            4'b0010: pos = 2'd1;
            4'b0100: pos = 2'd2;
            4'b1000: pos = 2'd3;
            default: pos = 2'd0;
        endcase
        dec       = seg_decode(seg_s2_q);
        idle_sel  = (sel_s2_q == 4'h0) || (sel_s2_q == 4'hF);
        onehot    = $onehot(sel_s2_q);
        minus_bad = (dec[3:0] == DigMinus) && (pos != 2'd3);
        acc_ok    = accept && !idle_sel && onehot && dec[4] && !minus_bad;
        acc_err   = accept && !idle_sel && !(onehot && dec[4] && !minus_bad);
        base_mask = (state_q == StCollect) ? mask_q : 4'h0;
        // A repeated position restarts the frame so any scan order works.
        mask_acc  = ((base_mask & sel_s2_q) != 4'h0) ? sel_s2_q : (base_mask | sel_s2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (acc_ok) state_d = StCollect;
            end
            StCollect, StAssemble: begin
                if (acc_err) begin
                    state_d = StIdle;
                end else if (acc_ok && (mask_acc == 4'hF)) begin
                    state_d = StAssemble;
                end else begin
                    state_d = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mag   = 15'(dig_q[2]) * 15'd100 + 15'(dig_q[1]) * 15'd10 + 15'(dig_q[0]);
        asm_v = (dig_q[3] == DigMinus) ? -mag : 15'(dig_q[3]) * 15'd1000 + mag;

        mask_d       = base_mask;
        dig_d        = dig_q;
        frame_done_d = (state_q == StAssemble);
        frame_v_d    = (state_q == StAssemble) ? asm_v : frame_v_q;
        err_d        = acc_err;
        if (acc_err) begin
            mask_d = 4'h0;
        end else if (acc_ok) begin
            mask_d     = mask_acc;
            dig_d[pos] = dec[3:0];
        end

        run_d    = run_q;
        prev_v_d = prev_v_q;
        value_d  = value_q;
        strobe_d = 1'b0;
        tmo_d    = (tmo_q == TmoMax) ? tmo_q : tmo_q + TW'(1);
        if (frame_done_q) begin
            tmo_d    = '0;
            prev_v_d = frame_v_q;
            if (frame_v_q != prev_v_q) begin
                run_d = RW'(1);
            end else if (run_q != RunMax) begin
                run_d = run_q + RW'(1);
            end
            if ((run_d == RunMax) && ((frame_v_q != prev_v_q) || (run_q != RunMax))) begin
                value_d  = frame_v_q;
                strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1_q     <= '0;
            sel_s2_q     <= '0;
            seg_s1_q     <= '0;
            seg_s2_q     <= '0;
            smp_q        <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            dig_q        <= '0;
            frame_v_q    <= '0;
            frame_done_q <= 1'b0;
            prev_v_q     <= '0;
            run_q        <= '0;
            value_q      <= '0;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            sel_s1_q     <= seg7_sel_in;
            sel_s2_q     <= sel_s1_q;
            seg_s1_q     <= seg7_in[6:0];
            seg_s2_q     <= seg_s1_q;
            smp_q        <= {sel_s2_q, seg_s2_q};
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            dig_q        <= dig_d;
            frame_v_q    <= frame_v_d;
            frame_done_q <= frame_done_d;
            prev_v_q     <= prev_v_d;
            run_q        <= run_d;
            value_q      <= value_d;
            strobe_q     <= strobe_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign value        = value_q;
    assign value_strobe = strobe_q;
    assign frame_err    = err_q;
    assign stale        = (tmo_q == TmoMax);

endmodule
